mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before a data access is aborted.
REQ-002 clk_i  in  1  sole clock; all state updates on posedge clk_i.
REQ-003 rst_n_i  in  1  synchronous, active-low reset, sampled on posedge clk_i.
REQ-004 ALUres_i  in  32  ALU result from EX/MEM; data address for loads and stores.
REQ-005 wrdata_i  in  32  store data from EX/MEM.
REQ-006 MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  in  1 each  EX/MEM control bits.
REQ-007 WriteBackPath_i  in  5  destination register index from EX/MEM.
REQ-008 mem_req_o  out  1  data-memory request, held until ack.
REQ-009 mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o=1.
REQ-010 mem_addr_o, mem_wdata_o  out  32 each  latched address and write data.
REQ-011 mem_ack_i  in  1  single-cycle completion strobe from memory.
REQ-012 mem_rdata_i  in  32  read data, valid in the cycle mem_ack_i=1.
REQ-013 stall_o  out  1  upstream stages, including EX/MEM, hold while 1.
REQ-014 ALUres_o, rddata_o  out  32 each  MEM/WB register: ALU result and load data.
REQ-015 RegWrite_o, MemtoReg_o  out  1 each; WriteBackPath_o  out  5  MEM/WB control outputs.
REQ-016 err_o  out  1  sticky error flag: timeout, misaligned address, or illegal access.

Function
REQ-017 States: IDLE, WAIT, DONE. Access = MemRead_i|MemWrite_i.
REQ-018 IDLE, no access: MEM/WB outputs load the *_i values each edge; rddata_o <= 0; stall_o=0.
REQ-019 IDLE, legal access: stall_o=1 combinationally. On the next edge: latch addr, wdata and we; mem_req_o<=1; wait counter<=0; MEM/WB loads a bubble (RegWrite_o=0, MemtoReg_o=0, WriteBackPath_o=0); go to WAIT.
REQ-020 Illegal access is either MemRead_i and MemWrite_i both set, or ALUres_i[1:0]!=0. The block issues no request, sets err_o<=1, loads a bubble into MEM/WB, stall_o=0, and stays in IDLE.
REQ-021 WAIT: stall_o=1; mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable; the counter increments each cycle without ack.
REQ-022 WAIT with mem_ack_i=1, on that edge:
  - mem_req_o<=0
  - rddata_o<=mem_rdata_i for a read, 0 for a write
  - ALUres_o, RegWrite_o, MemtoReg_o and WriteBackPath_o load the held *_i values
  - go to DONE.
REQ-023 WAIT with counter==TIMEOUT_CYCLES-1 and no ack: mem_req_o<=0, err_o<=1, MEM/WB loads a bubble, go to DONE.
REQ-024 If ack and timeout occur in the same cycle, ack wins (REQ-022).
REQ-025 DONE: stall_o=0 so upstream advances at this edge; no new access starts in DONE; MEM/WB loads a bubble; go to IDLE unconditionally.
REQ-026 Latency: with ack in the first WAIT cycle, the load result is visible on MEM/WB 2 cycles after the access is detected; stall_o is high for exactly 2 cycles.
REQ-027 mem_ack_i outside WAIT is ignored.
REQ-028 err_o, once set, stays 1 until reset.

Reset
REQ-029 rst_n_i=0 at an edge sets state IDLE, counter 0, and all outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ALUres_o, rddata_o, RegWrite_o, MemtoReg_o, WriteBackPath_o, err_o). stall_o follows combinationally.
REQ-030 Reset during WAIT abandons the access: mem_req_o=0 from the following cycle, and a late ack is ignored.

Verification
REQ-031 ALU op: ALUres_i=0x10, RegWrite_i=1, WriteBackPath_i=5, no access -> next cycle ALUres_o=0x10, RegWrite_o=1, WriteBackPath_o=5, stall_o=0.
REQ-032 Load: ALUres_i=0x100, MemRead_i=1, MemtoReg_i=1, RegWrite_i=1; memory acks in the 3rd WAIT cycle with 0xDEADBEEF -> mem_req_o high 3 cycles, stall_o high 4 cycles, rddata_o=0xDEADBEEF and RegWrite_o=1 in DONE.
REQ-033 Store: ALUres_i=0x20, wrdata_i=0xA5A5A5A5, MemWrite_i=1 -> mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0xA5A5A5A5 while mem_req_o=1; RegWrite_o=0 throughout.
REQ-034 Timeout, TIMEOUT_CYCLES=4, no ack -> mem_req_o drops after 4 WAIT cycles, err_o=1, RegWrite_o=0; next ALU op passes normally with err_o still 1.
REQ-035 Misaligned load at 0x102 -> mem_req_o stays 0, err_o=1, stall_o=0, bubble in MEM/WB.
REQ-036 rst_n_i=0 in the 2nd WAIT cycle, ack on the next cycle -> all outputs 0, state IDLE, ack ignored, err_o=0.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline MEM stage with a handshaked data-memory port, wait
//            timeout, alignment checking and a MEM/WB output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // EX/MEM register
    input  logic [31:0] ALUres_i,
    input  logic [31:0] wrdata_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic [4:0]  WriteBackPath_i,
    // data-memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    // pipeline control
    output logic        stall_o,
    // MEM/WB register
    output logic [31:0] ALUres_o,
    output logic [31:0] rddata_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [4:0]  WriteBackPath_o,
    output logic        err_o
);

    localparam int                c_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_access;
    logic               w_illegal;
    logic               w_cntLast;

    assign w_access  = MemRead_i | MemWrite_i;
    assign w_illegal = w_access & ((MemRead_i & MemWrite_i) | (ALUres_i[1:0] != 2'b00));
    assign w_cntLast = (r_cnt == c_TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        stall_o     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_access && !w_illegal) begin
                    stall_o     = 1'b1;
                    w_nextState = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                stall_o = 1'b1;
                if (mem_ack_i || w_cntLast) begin
                    w_nextState = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_nextState = c_ST_IDLE;
            end
            default: begin
                w_nextState = c_ST_IDLE;
            end
        endcase
    end

    // Memory port, wait counter, error flag and MEM/WB register.
    // EX/MEM is frozen while stalled, so the *_i values are still the
    // access's own control bits when the ack arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt           <= '0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= 32'd0;
            mem_wdata_o     <= 32'd0;
            ALUres_o        <= 32'd0;
            rddata_o        <= 32'd0;
            RegWrite_o      <= 1'b0;
            MemtoReg_o      <= 1'b0;
            WriteBackPath_o <= 5'd0;
            err_o           <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_access) begin
                        ALUres_o        <= ALUres_i;
                        rddata_o        <= 32'd0;
                        RegWrite_o      <= RegWrite_i;
                        MemtoReg_o      <= MemtoReg_i;
                        WriteBackPath_o <= WriteBackPath_i;
                    end else begin
                        ALUres_o        <= 32'd0;
                        rddata_o        <= 32'd0;
                        RegWrite_o      <= 1'b0;
                        MemtoReg_o      <= 1'b0;
                        WriteBackPath_o <= 5'd0;
                        if (w_illegal) begin
                            err_o <= 1'b1;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= MemWrite_i;
                            mem_addr_o  <= ALUres_i;
                            mem_wdata_o <= wrdata_i;
                            r_cnt       <= '0;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o       <= 1'b0;
                        rddata_o        <= mem_we_o ? 32'd0 : mem_rdata_i;
                        ALUres_o        <= ALUres_i;
                        RegWrite_o      <= RegWrite_i;
                        MemtoReg_o      <= MemtoReg_i;
                        WriteBackPath_o <= WriteBackPath_i;
                    end else if (w_cntLast) begin
                        mem_req_o       <= 1'b0;
                        err_o           <= 1'b1;
                        ALUres_o        <= 32'd0;
                        rddata_o        <= 32'd0;
                        RegWrite_o      <= 1'b0;
                        MemtoReg_o      <= 1'b0;
                        WriteBackPath_o <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    ALUres_o        <= 32'd0;
                    rddata_o        <= 32'd0;
                    RegWrite_o      <= 1'b0;
                    MemtoReg_o      <= 1'b0;
                    WriteBackPath_o <= 5'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Scoreboard bench for mem_stage: instruction-level reference model
//            feeds a per-cycle expectation queue consumed by a monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] ALUres_i, wrdata_i, mem_rdata_i;
    logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i, mem_ack_i;
    logic [4:0]  WriteBackPath_i;
    logic        mem_req_o, mem_we_o, stall_o, RegWrite_o, MemtoReg_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, ALUres_o, rddata_o;
    logic [4:0]  WriteBackPath_o;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ALUres_i(ALUres_i), .wrdata_i(wrdata_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .WriteBackPath_i(WriteBackPath_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o),
        .ALUres_o(ALUres_o), .rddata_o(rddata_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .WriteBackPath_o(WriteBackPath_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // One entry per clock cycle: stall during the cycle, registers after its edge.
    typedef struct {
        logic        stall;
        logic        req;
        logic        chkMem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        bubble;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        rw;
        logic        m2r;
        logic [4:0]  wbp;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nPass   = 0;
    logic errModel = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t bub(input logic st, input logic rq);
        exp_t e;
        e.stall = st; e.req = rq; e.chkMem = 1'b0; e.we = 1'b0;
        e.addr = 32'd0; e.wdata = 32'd0; e.bubble = 1'b1;
        e.alu = 32'd0; e.rd = 32'd0; e.rw = 1'b0; e.m2r = 1'b0; e.wbp = 5'd0;
        e.err = 1'b0;
        return e;
    endfunction

    // Monitor: stall checked mid-cycle, MEM/WB and port checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q[0];
                chk("stall", {31'd0, stall_o}, {31'd0, e.stall});
                @(posedge clk_i);
                #1;
                chk("mem_req", {31'd0, mem_req_o}, {31'd0, e.req});
                if (e.chkMem) begin
                    chk("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
                    chk("mem_addr", mem_addr_o, e.addr);
                    chk("mem_wdata", mem_wdata_o, e.wdata);
                end
                chk("RegWrite", {31'd0, RegWrite_o}, {31'd0, e.rw});
                chk("MemtoReg", {31'd0, MemtoReg_o}, {31'd0, e.m2r});
                chk("WriteBackPath", {27'd0, WriteBackPath_o}, {27'd0, e.wbp});
                if (!e.bubble) begin
                    chk("ALUres", ALUres_o, e.alu);
                    chk("rddata", rddata_o, e.rd);
                end
                chk("err", {31'd0, err_o}, {31'd0, e.err});
                void'(q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    // Issue one EX/MEM instruction; k = WAIT cycle carrying the ack (k > TO: never).
    task automatic runInstr(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                            input logic wr, input logic rw, input logic m2r,
                            input logic [4:0] wbp, input int k);
        logic        access, illegal;
        logic [31:0] rdat;
        int          n, last;
        exp_t        e;
        access  = rd | wr;
        illegal = access && ((rd && wr) || (a[1:0] != 2'b00));
        rdat    = $urandom;
        last    = (k <= TO) ? k : TO;
        ALUres_i = a; wrdata_i = wd; MemRead_i = rd; MemWrite_i = wr;
        RegWrite_i = rw; MemtoReg_i = m2r; WriteBackPath_i = wbp;
        if (!access) begin
            n = 1;
            e = bub(1'b0, 1'b0);
            e.bubble = 1'b0; e.alu = a; e.rw = rw; e.m2r = m2r; e.wbp = wbp;
            e.err = errModel;
            q.push_back(e);
        end else if (illegal) begin
            n = 1;
            errModel = 1'b1;
            e = bub(1'b0, 1'b0);
            e.err = 1'b1;
            q.push_back(e);
        end else begin
            n = last + 2;
            for (int c = 0; c <= last; c++) begin
                e = bub(1'b1, 1'b1);
                e.chkMem = 1'b1; e.we = wr; e.addr = a; e.wdata = wd;
                if (c == last) begin
                    e.req = 1'b0; e.chkMem = 1'b0;
                    if (k <= TO) begin
                        e.bubble = 1'b0; e.alu = a; e.rd = wr ? 32'd0 : rdat;
                        e.rw = rw; e.m2r = m2r; e.wbp = wbp;
                    end else begin
                        errModel = 1'b1;
                    end
                end
                e.err = errModel;
                q.push_back(e);
            end
            e = bub(1'b0, 1'b0);
            e.err = errModel;
            q.push_back(e);
        end
        for (int c = 0; c < n; c++) begin
            mem_rdata_i = $urandom;
            if (access && !illegal && c == k && k <= TO) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdat;
            end else if (access && !illegal && c >= 1 && c <= last) begin
                mem_ack_i = 1'b0;
            end else begin
                mem_ack_i = ($urandom_range(0, 3) == 0);
            end
            cyc();
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic zeroInputs();
        ALUres_i = 32'd0; wrdata_i = 32'd0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        RegWrite_i = 1'b0; MemtoReg_i = 1'b0; WriteBackPath_i = 5'd0;
    endtask

    initial begin
        #200000;
        nChecks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        exp_t z;
        logic [31:0] a;
        logic        rd, wr;
        int          kind;
        z = bub(1'b0, 1'b0);
        z.chkMem = 1'b1; z.bubble = 1'b0;

        rst_n_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        zeroInputs();
        cyc(); cyc();
        q.push_back(z);
        cyc();
        rst_n_i = 1'b1;

        // Directed scenarios
        runInstr(32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 0);
        runInstr(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 3);
        runInstr(32'h20, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2);
        runInstr(32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, TO);
        runInstr(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, TO + 1);
        runInstr(32'h44, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 0);
        runInstr(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1);
        runInstr(32'h80, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 1);

        // Reset in the 2nd WAIT cycle, then a late ack
        ALUres_i = 32'h40; wrdata_i = 32'h0; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        RegWrite_i = 1'b1; MemtoReg_i = 1'b1; WriteBackPath_i = 5'd3;
        for (int c = 0; c < 2; c++) begin
            z = bub(1'b1, 1'b1);
            z.chkMem = 1'b1; z.addr = 32'h40; z.err = errModel;
            q.push_back(z);
            cyc();
        end
        rst_n_i = 1'b0;
        errModel = 1'b0;
        z = bub(1'b1, 1'b0);
        z.chkMem = 1'b1; z.bubble = 1'b0;
        q.push_back(z);
        cyc();
        rst_n_i = 1'b1;
        zeroInputs();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        z.stall = 1'b0;
        q.push_back(z);
        cyc();
        mem_ack_i = 1'b0;
        q.push_back(z);
        cyc();

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            rd   = 1'b0;
            wr   = 1'b0;
            if (kind == 4) begin
                if ($urandom_range(0, 1) == 1) begin
                    rd = 1'b1; wr = 1'b1;
                end else begin
                    rd = $urandom_range(0, 1); wr = !rd;
                    if (a[1:0] == 2'b00) a[0] = 1'b1;
                end
            end else if (kind >= 5) begin
                wr = $urandom_range(0, 1); rd = !wr;
                a[1:0] = 2'b00;
            end
            runInstr(a, $urandom, rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), $urandom_range(1, TO + 1));
        end

        zeroInputs();
        cyc(); cyc();
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
